univ_shift_reg_n: RTL and testbench

UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

---
 rtl/univ_shift_reg_n.sv | 106 ++++++++++
 tb/tb_univ_shift_reg_n.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register: hold, shift right/left with serial fill or
// rotate, parallel load, plus a saturating shift counter with a one-shot done pulse.
module univ_shift_reg_n #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_t            mode_e;
  logic [WIDTH-1:0] pout_reg, pout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] shr_vec, shl_vec;
  logic             fill_r, fill_l;
  logic             cnt_sat;

  assign mode_e  = mode_t'(mode);
  assign cnt_sat = (cnt_reg == CNT_MAX);

  // Bit entering at each end: serial input, or the bit leaving the opposite end.
  assign fill_r = rot ? pout_reg[0]       : sin_r;
  assign fill_l = rot ? pout_reg[WIDTH-1] : sin_l;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_vec[gi] = fill_r;
      end else begin : g_shr
        assign shr_vec[gi] = pout_reg[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = fill_l;
      end else begin : g_shl
        assign shl_vec[gi] = pout_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    pout_next = pout_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (en) begin
      case (mode_e)
        MODE_HOLD: ;
        MODE_SHR, MODE_SHL: begin
          pout_next = (mode_e == MODE_SHR) ? shr_vec : shl_vec;
          if (!cnt_sat) begin
            cnt_next = cnt_reg + CW'(1);
          end
          // Only the WIDTH-1 -> WIDTH transition fires; saturated shifts stay quiet.
          done_next = (cnt_reg == CNT_LAST);
        end
        MODE_LOAD: begin
          pout_next = pin;
          cnt_next  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout_reg <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      pout_reg <= pout_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign pout   = pout_reg;
  assign sout_r = pout_reg[0];
  assign sout_l = pout_reg[WIDTH-1];
  assign cnt    = cnt_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n (WIDTH=4): directed scenarios and random traffic
// checked against an arithmetic reference model.
module tb_univ_shift_reg_n;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         rot;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] pin;
  logic [W-1:0] pout;
  logic         sout_r;
  logic         sout_l;
  logic [2:0]   cnt;
  logic         done;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_pout;
  int m_cnt;
  bit m_done;

  univ_shift_reg_n #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin), .pout(pout),
    .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pout"},   int'(pout),   m_pout);
    chk({tag, ".sout_r"}, int'(sout_r), m_pout % 2);
    chk({tag, ".sout_l"}, int'(sout_l), m_pout / 8);
    chk({tag, ".cnt"},    int'(cnt),    m_cnt);
    chk({tag, ".done"},   int'(done),   int'(m_done));
  endtask

  // Reference behaviour written as plain arithmetic on an integer register.
  task automatic model_edge(input bit e, input int md, input bit r, input bit sr,
                            input bit sl, input int p);
    bit shift;
    shift  = e && (md == 1 || md == 2);
    m_done = shift && (m_cnt == W - 1);
    if (e && md == 1)
      m_pout = (m_pout / 2) + 8 * (r ? (m_pout % 2) : int'(sr));
    else if (e && md == 2)
      m_pout = ((m_pout * 2) % 16) + (r ? (m_pout / 8) : int'(sl));
    else if (e && md == 3)
      m_pout = p;
    if (e && md == 3) m_cnt = 0;
    else if (shift && m_cnt < W) m_cnt = m_cnt + 1;
  endtask

  task automatic step(input string tag, input bit e, input int md, input bit r,
                      input bit sr, input bit sl, input int p);
    en = e; mode = md[1:0]; rot = r; sin_r = sr; sin_l = sl; pin = p[W-1:0];
    @(posedge clk);
    model_edge(e, md, r, sr, sl, p);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges; released before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_pout = 0; m_cnt = 0; m_done = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_r[4];
    int exp_l[4];
    int done_seen;
    exp_r = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    exp_l = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rst_n = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; pin = '0;
    m_pout = 0; m_cnt = 0; m_done = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 1011, shift right with zero fill
    step("r_load", 1, 3, 0, 0, 0, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      step("r_shift", 1, 1, 0, 0, 0, 0);
      chk("r_const", int'(pout), exp_r[i]);
    end
    step("r_after", 1, 0, 0, 0, 0, 0);

    // Load 1000, rotate left, then one extra rotate past saturation
    step("l_load", 1, 3, 0, 0, 0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      step("l_rot", 1, 2, 1, 0, 0, 0);
      chk("l_const", int'(pout), exp_l[i]);
    end
    step("l_rot5", 1, 2, 1, 0, 0, 0);
    chk("l_sat_cnt", int'(cnt), 4);

    // Fill left, hold via en=0, then shift right
    step("h_load", 1, 3, 0, 0, 0, 4'b0000);
    step("h_shl", 1, 2, 0, 0, 1, 0);
    step("h_shl", 1, 2, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("h_en0", 0, 2, 1, 1, 1, 4'hF);
    step("h_shr", 1, 1, 0, 0, 0, 0);
    chk("h_const", int'(pout), 4'b0001);

    // Reset mid-burst, then four fresh shifts
    step("x_load", 1, 3, 0, 0, 0, 4'b1111);
    for (int i = 0; i < 3; i++) step("x_shift", 1, 1, 0, 1, 0, 0);
    async_reset("x_rst");
    for (int i = 0; i < 4; i++) step("x_post", 1, 2, 0, 0, 1, 0);

    // Reload mid-burst clears count; exactly one done afterwards
    step("d_shift", 1, 1, 1, 0, 0, 0);
    step("d_shift", 1, 2, 0, 0, 0, 0);
    step("d_load", 1, 3, 0, 0, 0, 4'b0110);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step("d_mixed", 1, (i % 2) ? 1 : 2, i[0], 1, 0, 0);
      done_seen += int'(done);
    end
    chk("d_done_once", done_seen, 1);

    // Mode 00 holds while side inputs toggle
    step("m_load", 1, 3, 0, 0, 0, 4'b1010);
    for (int i = 0; i < 5; i++) step("m_hold", 1, 0, i[0], ~i[0], i[1], 4'h5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      else step("rnd", 1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
